sync_fifo_param: RTL
====================

# sync_fifo_param

Parametrised synchronous FIFO, successor to the fixed 8-bit × 16 FIFO. Width, depth and almost-full/almost-empty thresholds are configurable. Adds an occupancy count, programmable watermark flags, overflow/underflow error pulses and a synchronous flush. A compile-time first-word-fall-through (FWFT) read mode is also available. It is the general-purpose single-clock buffer between producer and consumer blocks.

## Interface
Parameters:
- DWIDTH, 8, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AFULL_TH, DEPTH-2, almost_full asserts when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserts when count ≤ AEMPTY_TH (0..DEPTH-1)

Ports (AW = $clog2(DEPTH)):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- clr  in  1  synchronous flush
- wr  in  1  write request
- din  in  DWIDTH  write data
- rd  in  1  read request (read acknowledge in FWFT mode)
- dout  out  DWIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_TH
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Pointers wr_ptr and rd_ptr are AW+1 bits; the MSB is the wrap bit and the low AW bits address storage.
- count = wr_ptr − rd_ptr, modulo 2^(AW+1).
- Write accepted iff wr && !full: mem[wr_ptr[AW-1:0]] ← din, then wr_ptr+1.
- Read accepted iff rd && !empty: rd_ptr+1.
- Pointer wrap: an address of DEPTH-1 goes to 0 on accept; the wrap bit toggles.
- Simultaneous wr && rd:
  - Neither full nor empty: both accepted; count unchanged.
  - Full: read accepted, write rejected.
  - Empty: write accepted, read rejected.
- Flags and count are registered and computed from next-state pointers, so they are exact on the cycle after the edge that changes them.
- Rejected write → overflow high for exactly the next cycle; rejected read → underflow high for exactly the next cycle. No state change from the rejected request.
- clr (while rst_n high): next edge zeroes both pointers and dout; flags go to their reset values. clr has priority over wr/rd in the same cycle, and no error pulse is generated.
- Reset values (rst_n low, asynchronous): wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0 (1 if AFULL_TH == 0 is illegal, so 0), dout = 0, overflow = underflow = 0.
- Storage contents are not reset.
- Reset asserted mid-operation discards all data; the first accepted write after release is the first word read.

## Timing
- Standard mode:
  - dout is registered and loaded with mem[rd_ptr] on the accepted-read edge; valid the cycle after the rd request.
  - dout holds its value otherwise.
  - Write at edge N → empty deasserts after N → earliest accepted read at N+1 → data on dout after N+1.
- Status latency: one edge for full, empty, almost_*, count and error pulses.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- FIFO_FWFT_EN defined:
  - dout presents mem[rd_ptr[AW-1:0]] whenever !empty, and 0 when empty.
  - rd acknowledges (pops) the displayed word; the next word appears after that edge.
  - A word written into an empty FIFO at edge N is on dout after N.
- FIFO_FWFT_EN undefined: standard registered read as in Timing.
- All flag, count, error and clr behaviour is identical in both modes.

## Structure
- Package fifo_pkg:
  - function fifo_aw(depth) returning $clog2(depth)
  - typedef fifo_status_t, a packed struct {full, empty, almost_full, almost_empty, overflow, underflow}
  - localparam defaults for DWIDTH and DEPTH
- Sub-module fifo_mem: DEPTH × DWIDTH register array with one synchronous write port and one asynchronous read port, no reset. The top holds pointers, flags and the dout register.
- Elaboration-time checks: DEPTH power of two and ≥4; AFULL_TH and AEMPTY_TH in range.

## Test plan
- Reset, then 16 writes of 0x01..0x10 (DEPTH = 16, AFULL_TH = 14) → almost_full after the 14th, full and count = 16 after the 16th. A 17th write → overflow pulse, count stays 16.
- Then 16 reads → dout 0x01..0x10 in order; empty after the 16th. A 17th read → underflow pulse, dout holds 0x10 (standard mode).
- 40 interleaved writes/reads with simultaneous wr && rd at count = 5 → count stays 5. Both pointers wrap twice, data order preserved.
- Fill to full, then assert wr && rd together → read accepted, write rejected, overflow = 1, count = 15.
- Write 3 words, then clr with wr = 1 in the same cycle → count = 0, empty = 1, dout = 0, no overflow. Drop rst_n asynchronously mid-burst → all outputs at reset values before the next edge.
- With FIFO_FWFT_EN: write 0xA5 into an empty FIFO → dout = 0xA5 the cycle after; rd → empty = 1, dout = 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types, defaults and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_DWIDTH_DEFAULT = 8;
    localparam int FIFO_DEPTH_DEFAULT  = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    localparam fifo_status_t FIFO_STATUS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

    function automatic int fifo_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// FIFO storage: DEPTH x DWIDTH register array, synchronous write, asynchronous read, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DWIDTH = FIFO_DWIDTH_DEFAULT,
    parameter int DEPTH  = FIFO_DEPTH_DEFAULT,
    parameter int AW     = fifo_aw(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count, watermark flags, error pulses and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DWIDTH    = FIFO_DWIDTH_DEFAULT,
    parameter int DEPTH     = FIFO_DEPTH_DEFAULT,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr,
    input  logic [DWIDTH-1:0]        din,
    input  logic                     rd,
    output logic [DWIDTH-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [fifo_aw(DEPTH):0]  count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = fifo_aw(DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_TH);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
    end
    if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_bad_afull
        $error("sync_fifo_param: AFULL_TH must lie in 1..DEPTH");
    end
    if ((AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)) begin : g_bad_aempty
        $error("sync_fifo_param: AEMPTY_TH must lie in 0..DEPTH-1");
    end
    if (DWIDTH < 1) begin : g_bad_dwidth
        $error("sync_fifo_param: DWIDTH must be at least 1");
    end

    logic [AW:0]       wr_ptr_reg, wr_ptr_next;
    logic [AW:0]       rd_ptr_reg, rd_ptr_next;
    logic [AW:0]       count_reg, count_next;
    fifo_status_t      status_reg, status_next;
    logic [DWIDTH-1:0] mem_rdata;
    logic              wr_acc, rd_acc;

    assign wr_acc = wr && !status_reg.full;
    assign rd_acc = rd && !status_reg.empty;

    // Flags come from next-state pointers so they are exact one edge after the change.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (clr) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
        end
        count_next               = wr_ptr_next - rd_ptr_next;
        status_next.full         = (count_next == DEPTH_C);
        status_next.empty        = (count_next == '0);
        status_next.almost_full  = (count_next >= AFULL_C);
        status_next.almost_empty = (count_next <= AEMPTY_C);
        status_next.overflow     = !clr && wr && status_reg.full;
        status_next.underflow    = !clr && rd && status_reg.empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            status_reg <= FIFO_STATUS_RST;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            status_reg <= status_next;
        end
    end

    fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc && !clr),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata (din),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (mem_rdata)
    );

`ifdef FIFO_FWFT_EN
    assign dout = status_reg.empty ? '0 : mem_rdata;
`else
    logic [DWIDTH-1:0] dout_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg <= '0;
        end else if (clr) begin
            dout_reg <= '0;
        end else if (rd_acc) begin
            dout_reg <= mem_rdata;
        end
    end

    assign dout = dout_reg;
`endif

    assign full         = status_reg.full;
    assign empty        = status_reg.empty;
    assign almost_full  = status_reg.almost_full;
    assign almost_empty = status_reg.almost_empty;
    assign overflow     = status_reg.overflow;
    assign underflow    = status_reg.underflow;
    assign count        = count_reg;

endmodule
